// File: rtl/keccak_axil_regs.sv
// AXI4-Lite register front end for the Keccak core: CONTROL/STATUS/INPUT/COMMAND/OUTPUT map.
// Latency: AW/W accept 1 cycle after both valid, BVALID 1 cycle later; RVALID 2 cycles after ARVALID.
// Backpressure: INPUT writes stall while a pushed word waits on core_in_ready; B/R hold until ready.
module keccak_axil_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int OUT_WORDS          = 16
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic                              core_rst,
    output logic [31:0]                       core_in_data,
    output logic [1:0]                        core_in_nbytes,
    output logic                              core_in_last,
    output logic                              core_in_valid,
    input  logic                              core_in_ready,
    input  logic [32*OUT_WORDS-1:0]           core_hash,
    input  logic                              core_done
);

    localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IW-1:0] IDX_CONTROL = IW'(0);
    localparam logic [IW-1:0] IDX_STATUS  = IW'(1);
    localparam logic [IW-1:0] IDX_INPUT   = IW'(2);
    localparam logic [IW-1:0] IDX_COMMAND = IW'(3);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [1:0]    ctrl_nbytes;
    logic          ctrl_last;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;
    logic          wr_mapped;
    logic          wr_stall;
    logic          wr_accept;
    logic          wr_hs;
    logic          wr_push;
    logic          wr_cmd_rst;
    logic          rd_accept;
    logic          rd_hs;
    logic [C_S_AXI_DATA_WIDTH-1:0] rd_data_next;
    logic [1:0]    rd_resp_next;

    assign wr_idx    = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_mapped = int'(wr_idx) < 4 + OUT_WORDS;

    // Only INPUT waits on the core; COMMAND must always get through to clear a wedged word.
    assign wr_stall  = (wr_idx == IDX_INPUT) && core_in_valid && !core_in_ready;
    assign wr_accept = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_AWREADY && !S_AXI_BVALID && !wr_stall;
    assign wr_hs     = S_AXI_AWREADY && S_AXI_WREADY && S_AXI_AWVALID && S_AXI_WVALID;
    assign wr_push   = wr_hs && (wr_idx == IDX_INPUT);
    assign wr_cmd_rst = wr_hs && (wr_idx == IDX_COMMAND) && S_AXI_WDATA[0];

    assign rd_accept = S_AXI_ARVALID && !S_AXI_ARREADY && !S_AXI_RVALID;
    assign rd_hs     = S_AXI_ARREADY && S_AXI_ARVALID;

    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_OKAY;
        if (rd_idx == IDX_CONTROL) begin
            rd_data_next[2:0] = {ctrl_last, ctrl_nbytes};
        end else if (rd_idx == IDX_STATUS) begin
            rd_data_next[1:0] = {core_in_valid, core_done};
        end else if (rd_idx == IDX_INPUT || rd_idx == IDX_COMMAND) begin
            rd_data_next = '0;
        end else if (int'(rd_idx) < 4 + OUT_WORDS) begin
            for (int k = 0; k < OUT_WORDS; k++) begin
                if (int'(rd_idx) == 4 + k) begin
                    rd_data_next = core_hash[32*k +: 32];
                end
            end
        end else begin
            rd_resp_next = RESP_SLVERR;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_AWREADY  <= 1'b0;
            S_AXI_WREADY   <= 1'b0;
            S_AXI_BVALID   <= 1'b0;
            S_AXI_BRESP    <= RESP_OKAY;
            ctrl_nbytes    <= 2'b00;
            ctrl_last      <= 1'b0;
            core_rst       <= 1'b0;
            core_in_data   <= '0;
            core_in_nbytes <= 2'b00;
            core_in_last   <= 1'b0;
            core_in_valid  <= 1'b0;
        end else begin
            S_AXI_AWREADY <= wr_accept;
            S_AXI_WREADY  <= wr_accept;
            core_rst      <= wr_cmd_rst;

            if (wr_hs) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
                if (wr_idx == IDX_CONTROL && S_AXI_WSTRB[0]) begin
                    ctrl_nbytes <= S_AXI_WDATA[1:0];
                    ctrl_last   <= S_AXI_WDATA[2];
                end
            end else if (S_AXI_BVALID && S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end

            if (wr_push) begin
                core_in_data   <= S_AXI_WDATA[31:0];
                core_in_nbytes <= ctrl_nbytes;
                core_in_last   <= ctrl_last;
            end

            if (wr_cmd_rst) begin
                core_in_valid <= 1'b0;
            end else if (wr_push) begin
                core_in_valid <= 1'b1;
            end else if (core_in_valid && core_in_ready) begin
                core_in_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
            S_AXI_RRESP   <= RESP_OKAY;
        end else begin
            S_AXI_ARREADY <= rd_accept;
            if (rd_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_data_next;
                S_AXI_RRESP  <= rd_resp_next;
            end else if (S_AXI_RVALID && S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                         S_AXI_WSTRB[C_S_AXI_DATA_WIDTH/8-1:1]};

endmodule

// File: tb/tb_keccak_axil_regs.sv
// Directed bench for keccak_axil_regs: register map, INPUT push/stall, COMMAND reset, read timing, errors.
module tb_keccak_axil_regs;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [6:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic        core_rst;
    logic [31:0] core_in_data;
    logic [1:0]  core_in_nbytes;
    logic        core_in_last;
    logic        core_in_valid;
    logic        core_in_ready = 1'b0;
    logic [511:0] core_hash = '0;
    logic        core_done = 1'b0;

    int tests = 0;
    int fails = 0;
    int vld_cyc = 0;
    int rst_cyc = 0;
    logic [34:0] rx_q[$];

    always #5 clk = ~clk;

    keccak_axil_regs dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .core_rst(core_rst), .core_in_data(core_in_data), .core_in_nbytes(core_in_nbytes),
        .core_in_last(core_in_last), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_hash(core_hash), .core_done(core_done)
    );

    // Core-side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (core_in_valid && core_in_ready) rx_q.push_back({core_in_last, core_in_nbytes, core_in_data});
            if (core_in_valid) vld_cyc++;
            if (core_rst) rst_cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr_begin(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    endtask

    task automatic wr_end(output logic [1:0] resp, output bit ok);
        ok = 1'b0; resp = 2'b11;
        for (int i = 0; i < TMO; i++) begin tick(1); if (awready) begin ok = 1'b1; break; end end
        if (!ok) begin awvalid = 1'b0; wvalid = 1'b0; return; end
        tick(1); awvalid = 1'b0; wvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin if (bvalid) begin ok = 1'b1; break; end tick(1); end
        if (!ok) return;
        resp = bresp; bready = 1'b1; tick(1); bready = 1'b0;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        wr_begin(a, d, s);
        wr_end(resp, ok);
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output bit ok);
        ok = 1'b0; d = 'x; resp = 2'b11;
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < TMO; i++) begin tick(1); if (arready) begin ok = 1'b1; break; end end
        if (!ok) begin arvalid = 1'b0; return; end
        tick(1); arvalid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin if (rvalid) begin ok = 1'b1; break; end tick(1); end
        if (!ok) return;
        d = rdata; resp = rresp; rready = 1'b1; tick(1); rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic [1:0] r; bit ok;
        tick(1);
        tests++;
        if ({awready, wready, bvalid, arready, rvalid, core_rst, core_in_valid} !== 7'b0) begin
            fails++; $display("FAIL reset_flags got=%b want=0000000",
                {awready, wready, bvalid, arready, rvalid, core_rst, core_in_valid});
        end
        tests++;
        if ({core_in_data, rdata, rresp, bresp} !== 68'h0) begin
            fails++; $display("FAIL reset_data in=%h rdata=%h rresp=%b bresp=%b", core_in_data, rdata, rresp, bresp);
        end
        rst_n = 1'b1;
        tick(1);
        axi_read(7'h00, d, r, ok);
        tests++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin
            fails++; $display("FAIL reset_control ok=%0d got=%h/%b want=00000000/00", ok, d, r);
        end
    endtask

    task automatic test_single_push();
        logic [31:0] d; logic [1:0] r; bit ok; int v0;
        axi_write(7'h00, 32'h4, 4'hF, r, ok);
        tests++;
        if (!ok || r !== 2'b00) begin fails++; $display("FAIL ctrl_wr ok=%0d bresp=%b want=00", ok, r); end
        axi_read(7'h00, d, r, ok);
        tests++;
        if (!ok || d !== 32'h4) begin fails++; $display("FAIL ctrl_rd got=%h want=00000004", d); end
        core_in_ready = 1'b1;
        rx_q.delete(); v0 = vld_cyc;
        axi_write(7'h08, 32'h00AABBCC, 4'hF, r, ok);
        tick(3);
        tests++;
        if (!ok || r !== 2'b00) begin fails++; $display("FAIL push_bresp ok=%0d bresp=%b want=00", ok, r); end
        tests++;
        if (rx_q.size() != 1 || rx_q[0] !== {1'b1, 2'b00, 32'h00AABBCC}) begin
            fails++; $display("FAIL push_word count=%0d first=%h want=1 word 4_00AABBCC", rx_q.size(),
                rx_q.size() > 0 ? rx_q[0] : 35'h0);
        end
        tests++;
        if (vld_cyc - v0 != 1) begin fails++; $display("FAIL push_valid_len got=%0d want=1", vld_cyc - v0); end
    endtask

    task automatic test_stall();
        logic [31:0] d; logic [1:0] r; bit ok; bit stalled_ok;
        core_in_ready = 1'b0;
        axi_write(7'h00, 32'h0, 4'hF, r, ok);
        rx_q.delete();
        axi_write(7'h08, 32'h54686520, 4'hF, r, ok);
        tests++;
        if (!ok || core_in_valid !== 1'b1 || core_in_data !== 32'h54686520) begin
            fails++; $display("FAIL stall_first ok=%0d valid=%b data=%h want=1/54686520", ok, core_in_valid, core_in_data);
        end
        axi_read(7'h04, d, r, ok);
        tests++;
        if (!ok || d !== 32'h2) begin fails++; $display("FAIL stall_status got=%h want=00000002", d); end
        wr_begin(7'h08, 32'h71756963, 4'hF);
        stalled_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (awready !== 1'b0 || wready !== 1'b0) stalled_ok = 1'b0;
        end
        tests++;
        if (!stalled_ok) begin fails++; $display("FAIL stall_ready awready/wready rose while stalled, want 0"); end
        tests++;
        if (core_in_data !== 32'h54686520) begin
            fails++; $display("FAIL stall_hold data=%h want=54686520", core_in_data);
        end
        core_in_ready = 1'b1;
        wr_end(r, ok);
        tick(3);
        tests++;
        if (!ok || rx_q.size() != 2) begin fails++; $display("FAIL stall_count ok=%0d got=%0d want=2", ok, rx_q.size()); end
        else begin
            tests++;
            if (rx_q[0] !== {3'b000, 32'h54686520} || rx_q[1] !== {3'b000, 32'h71756963}) begin
                fails++; $display("FAIL stall_order got=%h,%h want=0_54686520,0_71756963", rx_q[0], rx_q[1]);
            end
        end
    endtask

    task automatic test_command();
        logic [1:0] r; bit ok; int r0, q0;
        core_in_ready = 1'b0;
        axi_write(7'h08, 32'h11223344, 4'hF, r, ok);
        r0 = rst_cyc; q0 = rx_q.size();
        axi_write(7'h0C, 32'h1, 4'hF, r, ok);
        tests++;
        if (!ok || r !== 2'b00) begin fails++; $display("FAIL cmd_bresp ok=%0d bresp=%b want=00", ok, r); end
        tests++;
        if (rst_cyc - r0 != 1 || core_rst !== 1'b0) begin
            fails++; $display("FAIL cmd_pulse cycles=%0d now=%b want=1/0", rst_cyc - r0, core_rst);
        end
        tests++;
        if (core_in_valid !== 1'b0) begin fails++; $display("FAIL cmd_drop valid=%b want=0", core_in_valid); end
        core_in_ready = 1'b1;
        tick(3);
        tests++;
        if (rx_q.size() != q0) begin fails++; $display("FAIL cmd_no_deliver got=%0d want=%0d", rx_q.size(), q0); end
        core_in_ready = 1'b0;
        axi_write(7'h08, 32'hCAFEF00D, 4'hF, r, ok);
        r0 = rst_cyc;
        axi_write(7'h0C, 32'h0, 4'hF, r, ok);
        tests++;
        if (rst_cyc != r0 || core_in_valid !== 1'b1) begin
            fails++; $display("FAIL cmd_zero pulses=%0d valid=%b want=0/1", rst_cyc - r0, core_in_valid);
        end
        core_in_ready = 1'b1;
        tick(3);
        tests++;
        if (rx_q.size() != q0 + 1 || rx_q[rx_q.size()-1] !== {3'b000, 32'hCAFEF00D}) begin
            fails++; $display("FAIL cmd_zero_deliver count=%0d want=%0d", rx_q.size(), q0 + 1);
        end
    endtask

    task automatic test_output_read();
        logic [31:0] d; logic [1:0] r; bit ok; bit stable_ok;
        core_done = 1'b1;
        core_hash[31:0] = 32'hA7FFC6F8;
        core_hash[511:480] = 32'hDEADBEEF;
        axi_read(7'h04, d, r, ok);
        tests++;
        if (!ok || d !== 32'h1 || r !== 2'b00) begin fails++; $display("FAIL status_done got=%h/%b want=00000001/00", d, r); end
        araddr = 7'h10; arvalid = 1'b1;
        tick(1);
        tests++;
        if (arready !== 1'b1 || rvalid !== 1'b0) begin
            fails++; $display("FAIL lat_cycle1 arready=%b rvalid=%b want=1/0", arready, rvalid);
        end
        tick(1);
        arvalid = 1'b0;
        tests++;
        if (rvalid !== 1'b1 || rdata !== 32'hA7FFC6F8 || rresp !== 2'b00) begin
            fails++; $display("FAIL lat_cycle2 rvalid=%b rdata=%h want=1/A7FFC6F8", rvalid, rdata);
        end
        core_hash[31:0] = 32'h0;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (rvalid !== 1'b1 || rdata !== 32'hA7FFC6F8) stable_ok = 1'b0;
        end
        tests++;
        if (!stable_ok) begin fails++; $display("FAIL out_stable rvalid=%b rdata=%h want=1/A7FFC6F8", rvalid, rdata); end
        rready = 1'b1; tick(1); rready = 1'b0;
        tests++;
        if (rvalid !== 1'b0) begin fails++; $display("FAIL out_rclear rvalid=%b want=0", rvalid); end
        axi_read(7'h4C, d, r, ok);
        tests++;
        if (!ok || d !== 32'hDEADBEEF || r !== 2'b00) begin fails++; $display("FAIL out_last got=%h/%b want=DEADBEEF/00", d, r); end
        axi_read(7'h50, d, r, ok);
        tests++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin fails++; $display("FAIL out_past_end got=%h/%b want=00000000/10", d, r); end
    endtask

    task automatic test_errors();
        logic [31:0] d; logic [1:0] r; bit ok; bit stable_ok; int q0;
        axi_write(7'h00, 32'h5, 4'hF, r, ok);
        q0 = rx_q.size();
        araddr = 7'h7C; arvalid = 1'b1;
        tick(2);
        arvalid = 1'b0;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (rvalid !== 1'b1 || rdata !== 32'h0 || rresp !== 2'b10) stable_ok = 1'b0;
            tick(1);
        end
        tests++;
        if (!stable_ok) begin fails++; $display("FAIL err_read rvalid=%b rdata=%h rresp=%b want=1/0/10", rvalid, rdata, rresp); end
        rready = 1'b1; tick(1); rready = 1'b0;
        axi_write(7'h60, 32'hFFFFFFFF, 4'hF, r, ok);
        tests++;
        if (!ok || r !== 2'b10) begin fails++; $display("FAIL err_write ok=%0d bresp=%b want=10", ok, r); end
        axi_write(7'h04, 32'hFFFFFFFF, 4'hF, r, ok);
        tests++;
        if (!ok || r !== 2'b00) begin fails++; $display("FAIL ro_write bresp=%b want=00", r); end
        axi_write(7'h00, 32'h2, 4'h0, r, ok);
        axi_read(7'h00, d, r, ok);
        tests++;
        if (!ok || d !== 32'h5) begin fails++; $display("FAIL err_nochange control=%h want=00000005", d); end
        tests++;
        if (rx_q.size() != q0 || core_in_valid !== 1'b0) begin
            fails++; $display("FAIL err_nopush count=%0d valid=%b want=%0d/0", rx_q.size(), core_in_valid, q0);
        end
        axi_read(7'h08, d, r, ok);
        tests++;
        if (!ok || d !== 32'h0 || r !== 2'b00) begin fails++; $display("FAIL input_rd got=%h/%b want=00000000/00", d, r); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_stall();
        test_command();
        test_output_read();
        test_errors();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keccak_axil_regs.md
Name: keccak_axil_regs

Overview:
AXI4-Lite responder (slave) register front end that sits between the PS/master AXI4-Lite bus and the Keccak hashing core. It decodes the CONTROL/STATUS/INPUT/COMMAND/OUTPUT register map. It turns INPUT writes into a valid/ready word push toward the core and COMMAND writes into a one-cycle core reset pulse, and it serves hash result words on reads. It applies write back-pressure while a previously pushed word has not yet been accepted by the core.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 7, AXI byte address width.
OUT_WORDS, 16, number of 32-bit hash words readable at OUTPUT (0x10 + 4*k).

Ports:
S_AXI_ACLK  in  1  single clock for bus and core side.
S_AXI_ARESETN  in  1  asynchronous active-low reset.
S_AXI_AWADDR / S_AXI_AWPROT / S_AXI_AWVALID / S_AXI_AWREADY  in/in/in/out  7/3/1/1  write address channel; AWPROT ignored.
S_AXI_WDATA / S_AXI_WSTRB / S_AXI_WVALID / S_AXI_WREADY  in/in/in/out  32/4/1/1  write data channel.
S_AXI_BRESP / S_AXI_BVALID / S_AXI_BREADY  out/out/in  2/1/1  write response channel.
S_AXI_ARADDR / S_AXI_ARPROT / S_AXI_ARVALID / S_AXI_ARREADY  in/in/in/out  7/3/1/1  read address channel; ARPROT ignored.
S_AXI_RDATA / S_AXI_RRESP / S_AXI_RVALID / S_AXI_RREADY  out/out/out/in  32/2/1/1  read data channel.
core_rst  out  1  one-cycle synchronous reset pulse to the core.
core_in_data  out  32  input word; byte 0 = first message byte.
core_in_nbytes  out  2  valid bytes in word; 0 means 4.
core_in_last  out  1  word is the final word of the message.
core_in_valid  out  1  word pending.
core_in_ready  in  1  core accepts the word when valid && ready.
core_hash  in  32*OUT_WORDS  digest; word k = bits [32k+31:32k].
core_done  in  1  digest valid.

Behaviour:
- Register map (word-aligned, addr[1:0] ignored):
  - 0x00 CONTROL RW: [1:0] nbytes, [2] last; other bits read 0; WSTRB byte 0 gates the write.
  - 0x04 STATUS RO: [0] core_done, [1] core_in_valid, other bits 0.
  - 0x08 INPUT WO: reads 0.
  - 0x0C COMMAND WO: [0] reset; reads 0.
  - 0x10..0x10+4*(OUT_WORDS-1) OUTPUT RO: core_hash word k.
  - Any other address: write ignored, BRESP/RRESP = 2'b10 (SLVERR), RDATA = 0. Mapped accesses: 2'b00. Writes to RO registers are ignored with OKAY.
- Reset (async, ARESETN low): AWREADY, WREADY, BVALID, ARREADY, RVALID, core_rst, core_in_valid = 0; BRESP, RRESP, RDATA, CONTROL, core_in_data = 0. Reset mid-transaction abandons it; no response is issued afterwards.
- Write path:
  - Accept condition: AWVALID && WVALID && !AWREADY && !BVALID && !stall, where stall = (AWADDR == INPUT) && core_in_valid && !core_in_ready.
  - When the accept condition holds, AWREADY and WREADY are registered high together for exactly one cycle.
  - At the handshake edge: register side effects occur, BVALID <= 1, BRESP set.
  - BVALID holds until BREADY is sampled high, then clears. Only one write is outstanding.
- INPUT write at the handshake edge: core_in_data <= WDATA (WSTRB ignored), nbytes/last <= CONTROL, core_in_valid <= 1.
  - core_in_valid clears on the edge where valid && ready.
  - Data, nbytes and last stay stable while valid && !ready.
  - CONTROL is not auto-cleared after a last word.
- COMMAND write with bit0 = 1: core_rst high for exactly the next cycle; core_in_valid cleared at the same edge (pending word dropped). COMMAND is never stalled. Bit0 = 0 has no effect.
- Read path:
  - ARREADY is registered high for one cycle when ARVALID && !ARREADY && !RVALID.
  - At the handshake edge: RDATA is latched from the map, RVALID <= 1.
  - RVALID holds until RREADY, then clears. RDATA is stable while RVALID.
  - Read latency: 2 cycles from ARVALID to RVALID.
- Reads and writes proceed independently in the same cycle. A STATUS read concurrent with an INPUT push reflects state before the edge.

Test Plan:
- Reset: ARESETN low for 1 cycle -> all ready/valid outputs 0; CONTROL reads 0x00000000, RESP 00.
- Write CONTROL = 0x4 then INPUT = 0x00AABBCC, core_in_ready tied 1 -> one-cycle core_in_valid with data 0x00AABBCC, nbytes 0, last 1; BRESP 00.
- core_in_ready held 0, two INPUT writes "The " then "quic" -> second write's AWREADY/WREADY stay 0 and STATUS[1] = 1 until ready asserted; the core then receives 0x54686520 followed by 0x71756963 with no loss.
- COMMAND = 0x1 with a word pending -> core_rst is a single-cycle pulse, core_in_valid drops to 0, BVALID follows.
- core_done = 1, core_hash word0 = 0xA7FFC6F8 -> STATUS reads 0x1; OUTPUT (0x10) reads 0xA7FFC6F8 with RVALID 2 cycles after ARVALID.
- Read 0x7C and write 0x60 -> RRESP/BRESP = 10, RDATA 0, no state change; RREADY held low 5 cycles -> RVALID and RDATA stay stable.
